// File: rtl/fifo_v2.sv
// Synchronous FIFO with runtime almost-full/almost-empty thresholds, sticky error flags and flush.
// Latency: FWFT=0 gives data_out one edge after the accepted pop; FWFT=1 shows the head word one cycle after it is written.
// Backpressure: a push on full is dropped (overflow) unless a pop is accepted in the same cycle; a pop on empty is dropped (underflow).
module fifo_v2 #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int FWFT       = 0,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [CW-1:0]         af_level,
    input  logic [CW-1:0]         ae_level,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [CW-1:0]         count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  pop_acc;
    logic                  push_acc;

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= af_level);
    assign almost_empty = (count <= ae_level);

    // A pop frees a slot in the same cycle, so push on full succeeds alongside it.
    assign pop_acc  = pop && !empty;
    assign push_acc = push && (!full || pop_acc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (pop_acc) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({push_acc, pop_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            overflow  <= overflow  | (push && !push_acc);
            underflow <= underflow | (pop && empty);
        end
    end

    // Storage is deliberately not reset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (push_acc && !clr) begin
            mem[wr_ptr] <= data_in;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = empty ? '0 : mem[rd_ptr];
        end else begin : g_std
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_out <= '0;
                end else if (clr) begin
                    data_out <= '0;
                end else if (pop_acc) begin
                    data_out <= mem[rd_ptr];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_fifo_v2.sv
// Bench for fifo_v2: a standard-read and a FWFT instance share stimulus and are checked against a queue model.
module tb_fifo_v2;

    localparam int DW = 8;
    localparam int D  = 5;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic          clr = 1'b0;
    logic [DW-1:0] din = '0;
    logic [CW-1:0] af_level = '0;
    logic [CW-1:0] ae_level = '0;

    logic [DW-1:0] d0, d1;
    logic [CW-1:0] cnt0, cnt1;
    logic full0, empty0, af0, ae0, ovf0, unf0;
    logic full1, empty1, af1, ae1, ovf1, unf1;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] q [$];
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;
    logic [DW-1:0] m_d0  = '0;

    fifo_v2 #(.DATA_WIDTH(DW), .DEPTH(D), .FWFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .clr(clr),
        .data_in(din), .af_level(af_level), .ae_level(ae_level),
        .data_out(d0), .count(cnt0), .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .overflow(ovf0), .underflow(unf0)
    );

    fifo_v2 #(.DATA_WIDTH(DW), .DEPTH(D), .FWFT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .clr(clr),
        .data_in(din), .af_level(af_level), .ae_level(ae_level),
        .data_out(d1), .count(cnt1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .overflow(ovf1), .underflow(unf1)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_d0  = '0;
    endtask

    // One clock: drive on the falling edge, advance the model at the rising edge, return 1 time unit later.
    task automatic cyc(input logic pu, input logic po, input logic cl, input logic [DW-1:0] d);
        bit pa, wa;
        @(negedge clk);
        push = pu; pop = po; clr = cl; din = d;
        @(posedge clk);
        if (cl) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_d0  = '0;
        end else begin
            pa = po && (q.size() > 0);
            wa = pu && ((q.size() < D) || pa);
            if (po && q.size() == 0) m_unf = 1'b1;
            if (pu && !wa) m_ovf = 1'b1;
            if (pa) m_d0 = q.pop_front();
            if (wa) q.push_back(d);
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; af_level = 3'd0; ae_level = 3'd1;
        #2;
        total++; if (cnt0 !== 3'd0)  begin bad++; $display("FAIL reset_count got=%0d exp=0", cnt0); end
        total++; if (empty0 !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty0); end
        total++; if (full0 !== 1'b0)  begin bad++; $display("FAIL reset_full got=%b exp=0", full0); end
        total++; if (ae0 !== 1'b1)    begin bad++; $display("FAIL reset_ae got=%b exp=1", ae0); end
        total++; if (af0 !== 1'b1)    begin bad++; $display("FAIL reset_af_lvl0 got=%b exp=1", af0); end
        total++; if ({ovf0, unf0} !== 2'b00) begin bad++; $display("FAIL reset_err got=%b exp=00", {ovf0, unf0}); end
        total++; if (d0 !== 8'h00 || d1 !== 8'h00) begin bad++; $display("FAIL reset_dout got=%h/%h exp=00/00", d0, d1); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1; af_level = 3'd5; ae_level = 3'd0;
    endtask

    task automatic test_fill_overflow();
        logic [DW-1:0] e;
        for (int i = 0; i < D; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 8'h11 + 8'(i));
            total++; if (cnt0 !== CW'(i + 1)) begin bad++; $display("FAIL fill_count got=%0d exp=%0d", cnt0, i + 1); end
        end
        total++; if (full0 !== 1'b1) begin bad++; $display("FAIL fill_full got=%b exp=1", full0); end
        cyc(1'b1, 1'b0, 1'b0, 8'h99);
        total++; if (ovf0 !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", ovf0); end
        total++; if (cnt0 !== 3'd5) begin bad++; $display("FAIL ovf_count got=%0d exp=5", cnt0); end
        for (int i = 0; i < D; i++) begin
            e = 8'h11 + 8'(i);
            cyc(1'b0, 1'b1, 1'b0, 8'h00);
            total++; if (d0 !== e) begin bad++; $display("FAIL pop_data got=%h exp=%h", d0, e); end
        end
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        total++; if (d0 !== 8'h15 || empty0 !== 1'b1) begin bad++; $display("FAIL pop_hold got=%h/%b exp=15/1", d0, empty0); end
        total++; if (ovf0 !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", ovf0); end
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
    endtask

    task automatic test_wrap();
        logic [DW-1:0] exp_seq [5];
        exp_seq[0] = 8'h22; exp_seq[1] = 8'h23; exp_seq[2] = 8'h24; exp_seq[3] = 8'h25; exp_seq[4] = 8'hAA;
        for (int i = 0; i < D; i++) cyc(1'b1, 1'b0, 1'b0, 8'h21 + 8'(i));
        cyc(1'b1, 1'b1, 1'b0, 8'hAA);
        total++; if (cnt0 !== 3'd5 || full0 !== 1'b1) begin bad++; $display("FAIL wrap_count got=%0d exp=5", cnt0); end
        total++; if (ovf0 !== 1'b0) begin bad++; $display("FAIL wrap_ovf got=%b exp=0", ovf0); end
        total++; if (d0 !== 8'h21) begin bad++; $display("FAIL wrap_first got=%h exp=21", d0); end
        for (int i = 0; i < D; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 8'h00);
            total++; if (d0 !== exp_seq[i]) begin bad++; $display("FAIL wrap_data got=%h exp=%h", d0, exp_seq[i]); end
        end
        total++; if (empty0 !== 1'b1) begin bad++; $display("FAIL wrap_empty got=%b exp=1", empty0); end
    endtask

    task automatic test_fwft();
        cyc(1'b1, 1'b0, 1'b0, 8'h3C);
        total++; if (d1 !== 8'h3C) begin bad++; $display("FAIL fwft_show got=%h exp=3c", d1); end
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        total++; if (empty1 !== 1'b1 || d1 !== 8'h00) begin bad++; $display("FAIL fwft_drain got=%h/%b exp=00/1", d1, empty1); end
        total++; if (d0 !== 8'h3C) begin bad++; $display("FAIL std_after_pop got=%h exp=3c", d0); end
    endtask

    task automatic test_underflow();
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        total++; if (unf0 !== 1'b1 || cnt0 !== 3'd0) begin bad++; $display("FAIL unf_pop got=%b/%0d exp=1/0", unf0, cnt0); end
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        cyc(1'b1, 1'b1, 1'b0, 8'h5A);
        total++; if (cnt0 !== 3'd1 || unf0 !== 1'b1) begin bad++; $display("FAIL unf_pushpop got=%0d/%b exp=1/1", cnt0, unf0); end
        total++; if (d1 !== 8'h5A) begin bad++; $display("FAIL unf_pushpop_data got=%h exp=5a", d1); end
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
        total++; if (unf0 !== 1'b0 || cnt0 !== 3'd0) begin bad++; $display("FAIL unf_clr got=%b/%0d exp=0/0", unf0, cnt0); end
    endtask

    task automatic test_thresholds();
        af_level = 3'd3; ae_level = 3'd1;
        for (int c = 0; c <= 4; c++) begin
            if (c > 0) cyc(1'b1, 1'b0, 1'b0, 8'(c));
            #1;
            total++; if (ae0 !== (c <= 1)) begin bad++; $display("FAIL thr_ae c=%0d got=%b exp=%b", c, ae0, c <= 1); end
            total++; if (af0 !== (c >= 3)) begin bad++; $display("FAIL thr_af c=%0d got=%b exp=%b", c, af0, c >= 3); end
        end
        af_level = 3'd5;
        #1;
        total++; if (af0 !== 1'b0) begin bad++; $display("FAIL thr_af_live got=%b exp=0", af0); end
        cyc(1'b0, 1'b0, 1'b1, 8'h00);
    endtask

    task automatic test_clr_and_reset();
        for (int i = 0; i <= D; i++) cyc(1'b1, 1'b0, 1'b0, 8'h40 + 8'(i));
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        total++; if (cnt0 !== 3'd3 || ovf0 !== 1'b1) begin bad++; $display("FAIL clr_setup got=%0d/%b exp=3/1", cnt0, ovf0); end
        cyc(1'b1, 1'b0, 1'b1, 8'h77);
        total++; if (cnt0 !== 3'd0 || ovf0 !== 1'b0 || empty0 !== 1'b1) begin bad++; $display("FAIL clr_push got=%0d/%b/%b exp=0/0/1", cnt0, ovf0, empty0); end
        total++; if (d0 !== 8'h00) begin bad++; $display("FAIL clr_dout got=%h exp=00", d0); end
        cyc(1'b1, 1'b0, 1'b0, 8'h61);
        cyc(1'b1, 1'b0, 1'b0, 8'h62);
        cyc(1'b1, 1'b1, 1'b0, 8'h63);
        total++; if (d0 !== 8'h61 || cnt0 !== 3'd2) begin bad++; $display("FAIL burst got=%h/%0d exp=61/2", d0, cnt0); end
        @(negedge clk);
        push = 1'b1; pop = 1'b0; din = 8'h64;
        #2 rst_n = 1'b0;
        #1;
        total++; if (cnt0 !== 3'd0 || empty0 !== 1'b1) begin bad++; $display("FAIL arst_count got=%0d/%b exp=0/1", cnt0, empty0); end
        total++; if (d0 !== 8'h00 || d1 !== 8'h00) begin bad++; $display("FAIL arst_dout got=%h/%h exp=00/00", d0, d1); end
        model_reset();
        push = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic pu, po, cl;
        logic [DW-1:0] hd;
        for (int i = 0; i < 600; i++) begin
            af_level = CW'($urandom_range(0, 7));
            ae_level = CW'($urandom_range(0, 7));
            if (i < 200)      begin pu = ($urandom % 4) != 0; po = ($urandom % 4) == 0; end
            else if (i < 400) begin pu = ($urandom % 4) == 0; po = ($urandom % 4) != 0; end
            else              begin pu = $urandom % 2;        po = $urandom % 2;        end
            cl = ($urandom % 50) == 0;
            cyc(pu, po, cl, 8'($urandom));
            hd = (q.size() > 0) ? q[0] : 8'h00;
            total++; if (cnt0 !== CW'(q.size()) || cnt1 !== CW'(q.size())) begin bad++; $display("FAIL rnd_count i=%0d got=%0d/%0d exp=%0d", i, cnt0, cnt1, q.size()); end
            total++; if (full0 !== (q.size() == D) || empty0 !== (q.size() == 0)) begin bad++; $display("FAIL rnd_fe i=%0d got=%b%b exp=%b%b", i, full0, empty0, q.size() == D, q.size() == 0); end
            total++; if (af0 !== (q.size() >= af_level) || ae0 !== (q.size() <= ae_level)) begin bad++; $display("FAIL rnd_thr i=%0d got=%b%b exp=%b%b", i, af0, ae0, q.size() >= af_level, q.size() <= ae_level); end
            total++; if (ovf0 !== m_ovf || unf0 !== m_unf) begin bad++; $display("FAIL rnd_err i=%0d got=%b%b exp=%b%b", i, ovf0, unf0, m_ovf, m_unf); end
            total++; if (d0 !== m_d0) begin bad++; $display("FAIL rnd_std i=%0d got=%h exp=%h", i, d0, m_d0); end
            total++; if (d1 !== hd) begin bad++; $display("FAIL rnd_fwft i=%0d got=%h exp=%h", i, d1, hd); end
        end
    endtask

    initial begin
        test_reset();
        test_fill_overflow();
        test_wrap();
        test_fwft();
        test_underflow();
        test_thresholds();
        test_clr_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
